// File: rtl/imem_arbiter_if.sv
// Bundle of fetch, debug, flush and ROM signals around imem_arbiter.
// slave = arbiter side, master = requesters plus ROM (bench or system glue).
interface imem_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [DATA_W-1:0] if_rdata;
    logic              dbg_req;
    logic [ADDR_W-1:0] dbg_addr;
    logic              dbg_gnt;
    logic              dbg_rvalid;
    logic [DATA_W-1:0] dbg_rdata;
    logic              flush;
    logic              rom_en;
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_rdata;

    modport slave (
        input  if_req, if_addr, dbg_req, dbg_addr, flush, rom_rdata,
        output if_gnt, if_rvalid, if_rdata, dbg_gnt, dbg_rvalid, dbg_rdata,
               rom_en, rom_addr
    );

    modport master (
        output if_req, if_addr, dbg_req, dbg_addr, flush, rom_rdata,
        input  if_gnt, if_rvalid, if_rdata, dbg_gnt, dbg_rvalid, dbg_rdata,
               rom_en, rom_addr
    );
endinterface

// File: rtl/imem_arbiter.sv
// Shares the single-port instruction ROM between fetch and a debug read port.
// Optional starvation guard for the debug port: define IMEM_STARVE_GUARD_EN.
module imem_arbiter #(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int STARVE_MAX = 8
) (
    input  logic              clk,
    input  logic              reset,
    imem_arbiter_if.slave     bus,
    output logic [1:0]        owner
);
    // Handshake: a requester holds req with a stable address until its gnt is
    // high in the same cycle; the word returns with rvalid exactly one cycle later.

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_IF   = 2'd1,
        OWN_DBG  = 2'd2
    } owner_t;

    localparam logic [7:0] STARVE_LIM = 8'(STARVE_MAX);

    owner_t            owner_q;
    owner_t            owner_d;
    logic              if_ok;
    logic              dbg_win;
    logic              if_gnt_c;
    logic              dbg_gnt_c;
    logic              force_dbg;
    logic [ADDR_W-1:0] addr_mux;
    logic [DATA_W-1:0] rdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            owner_q <= OWN_NONE;
        end else begin
            owner_q <= owner_d;
        end
    end

    // Grants are suppressed during reset so a request held across reset is ignored.
    always_comb begin
        owner_d   = OWN_NONE;
        if_ok     = 1'b0;
        dbg_win   = 1'b0;
        if_gnt_c  = 1'b0;
        dbg_gnt_c = 1'b0;
        if (!reset) begin
            if_ok     = bus.if_req & ~bus.flush;
            dbg_win   = bus.dbg_req & (~if_ok | force_dbg);
            dbg_gnt_c = dbg_win;
            if_gnt_c  = if_ok & ~dbg_win;
        end
        if (dbg_gnt_c) begin
            owner_d = OWN_DBG;
        end else if (if_gnt_c) begin
            owner_d = OWN_IF;
        end
    end

`ifdef IMEM_STARVE_GUARD_EN
    logic [7:0] starve_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            starve_cnt <= 8'd0;
        end else if (dbg_gnt_c) begin
            starve_cnt <= 8'd0;
        end else if (bus.dbg_req && (starve_cnt != STARVE_LIM)) begin
            starve_cnt <= starve_cnt + 8'd1;
        end
    end

    assign force_dbg = (starve_cnt == STARVE_LIM);
`else
    logic [7:0] unused_starve_lim;
    assign unused_starve_lim = STARVE_LIM;
    assign force_dbg         = 1'b0;
`endif

    assign addr_mux     = dbg_gnt_c ? bus.dbg_addr : bus.if_addr;
    assign rdata        = bus.rom_rdata;

    assign bus.if_gnt   = if_gnt_c;
    assign bus.dbg_gnt  = dbg_gnt_c;
    assign bus.rom_en   = if_gnt_c | dbg_gnt_c;
    assign bus.rom_addr = addr_mux;

    // A flush in the response cycle kills a fetch word already read from the ROM.
    assign bus.if_rvalid  = (owner_q == OWN_IF) & ~bus.flush & ~reset;
    assign bus.dbg_rvalid = (owner_q == OWN_DBG) & ~reset;
    assign bus.if_rdata   = rdata;
    assign bus.dbg_rdata  = rdata;

    assign owner = owner_q;
endmodule

// File: tb/tb_imem_arbiter.sv
// Randomized bench for imem_arbiter with a cycle-level reference model and
// response scoreboards for the fetch and debug ports.
module tb_imem_arbiter;
    localparam int ADDR_W     = 32;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;

    logic       clk;
    logic       reset;
    logic [1:0] owner;

    imem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    imem_arbiter #(
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .STARVE_MAX(STARVE_MAX)
    ) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .owner(owner)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- ROM model ----------------
    function automatic logic [DATA_W-1:0] rom_word(input logic [ADDR_W-1:0] a);
        return {a[15:0] ^ 16'hA5C3, ~a[15:0]};
    endfunction

    always_ff @(posedge clk) begin
        if (bus.rom_en) bus.rom_rdata <= rom_word(bus.rom_addr);
    end

    // ---------------- scoreboard ----------------
    logic [DATA_W-1:0] if_exp_q[$];
    logic [DATA_W-1:0] dbg_exp_q[$];
    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model state ----------------
    int          prev_own;      // 0 none, 1 fetch, 2 debug
    logic [31:0] prev_addr;
    int          dbg_lost;      // consecutive cycles debug waited without a grant
    logic        m_if_gnt;
    logic        m_dbg_gnt;

    // Drive one cycle of inputs, predict this cycle's grants and responses.
    task automatic cycle(input logic rst, input logic ifr, input logic [31:0] ia,
                         input logic dr, input logic [31:0] da, input logic fl);
        logic if_ok;
        logic force_d;
        logic [31:0] exp_addr;
        @(negedge clk);
        reset       = rst;
        bus.if_req  = ifr;
        bus.if_addr = ia;
        bus.dbg_req = dr;
        bus.dbg_addr = da;
        bus.flush   = fl;
        #1;
        m_if_gnt  = 1'b0;
        m_dbg_gnt = 1'b0;
        if (rst) begin
            dbg_lost = 0;
            prev_own = 0;
        end else begin
            if (prev_own == 1 && !fl) if_exp_q.push_back(rom_word(prev_addr));
            if (prev_own == 2) dbg_exp_q.push_back(rom_word(prev_addr));
`ifdef IMEM_STARVE_GUARD_EN
            force_d = (dbg_lost >= STARVE_MAX);
`else
            force_d = 1'b0;
`endif
            if_ok = ifr && !fl;
            m_dbg_gnt = dr && (!if_ok || force_d);
            m_if_gnt  = if_ok && !m_dbg_gnt;
            if (m_dbg_gnt) dbg_lost = 0;
            else if (dr && dbg_lost < STARVE_MAX) dbg_lost = dbg_lost + 1;
            prev_own  = m_dbg_gnt ? 2 : (m_if_gnt ? 1 : 0);
            prev_addr = m_dbg_gnt ? da : ia;
        end
        exp_addr = m_dbg_gnt ? da : ia;
        chk("if_gnt", 64'(bus.if_gnt), 64'(m_if_gnt));
        chk("dbg_gnt", 64'(bus.dbg_gnt), 64'(m_dbg_gnt));
        chk("rom_en", 64'(bus.rom_en), 64'(m_if_gnt | m_dbg_gnt));
        chk("rom_addr", 64'(bus.rom_addr), 64'(exp_addr));
    endtask

    // ---------------- monitor ----------------
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (bus.if_rvalid === 1'b1) begin
                if (if_exp_q.size() == 0) chk("if_rvalid_unexpected", 64'd1, 64'd0);
                else chk("if_rdata", 64'(bus.if_rdata), 64'(if_exp_q.pop_front()));
            end
            if (bus.dbg_rvalid === 1'b1) begin
                if (dbg_exp_q.size() == 0) chk("dbg_rvalid_unexpected", 64'd1, 64'd0);
                else chk("dbg_rdata", 64'(bus.dbg_rdata), 64'(dbg_exp_q.pop_front()));
            end
        end
    end

    // ---------------- stimulus ----------------
    logic        cur_ifr;
    logic [31:0] cur_ia;
    logic        cur_dr;
    logic [31:0] cur_da;

    initial begin
        reset = 1'b1;
        bus.if_req = 1'b0;  bus.if_addr = '0;
        bus.dbg_req = 1'b0; bus.dbg_addr = '0;
        bus.flush = 1'b0;
        prev_own = 0; prev_addr = '0; dbg_lost = 0;

        // Reset with a fetch request pending, then first cycle out of reset.
        cycle(1, 1, 32'h10, 0, 0, 0);
        cycle(1, 1, 32'h10, 0, 0, 0);
        chk("reset_if_rvalid", 64'(bus.if_rvalid), 64'd0);
        cycle(0, 1, 32'h10, 0, 0, 0);
        chk("post_reset_if_gnt", 64'(bus.if_gnt), 64'd1);
        cycle(0, 0, 0, 0, 0, 0);

        // Back-to-back fetch.
        cycle(0, 1, 32'h34, 0, 0, 0);
        cycle(0, 1, 32'h38, 0, 0, 0);
        cycle(0, 1, 32'h3C, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);

        // Debug only.
        cycle(0, 0, 0, 1, 32'h100, 0);
        cycle(0, 0, 0, 0, 0, 0);

        // Both requesting continuously.
        for (int i = 0; i < 7; i++) cycle(0, 1, 32'h200, 1, 32'h300, 0);
        cycle(0, 0, 32'h200, 1, 32'h300, 0);
        cycle(0, 0, 0, 0, 0, 0);

        // Flush kills the in-flight fetch word; debug takes the ROM.
        cycle(0, 1, 32'h40, 0, 0, 0);
        cycle(0, 1, 32'h44, 1, 32'h180, 1);
        chk("flush_if_rvalid", 64'(bus.if_rvalid), 64'd0);
        cycle(0, 0, 0, 0, 0, 0);

        // Reset while a debug read is in flight.
        cycle(0, 0, 0, 1, 32'h120, 0);
        cycle(1, 0, 0, 0, 0, 0);
        chk("reset_dbg_rvalid", 64'(bus.dbg_rvalid), 64'd0);
        cycle(0, 0, 0, 0, 0, 0);
        chk("owner_after_reset", 64'(owner), 64'd0);

        // Randomized traffic honouring the hold-until-grant rule.
        cur_ifr = 1'b0; cur_ia = '0; cur_dr = 1'b0; cur_da = '0;
        for (int n = 0; n < 600; n++) begin
            if (!cur_ifr || m_if_gnt) begin
                cur_ifr = ($urandom_range(0, 99) < 65);
                cur_ia  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
            end
            if (!cur_dr || m_dbg_gnt) begin
                cur_dr = ($urandom_range(0, 99) < 35);
                cur_da = {20'd0, 10'($urandom_range(0, 1023)), 2'b00};
            end
            cycle(($urandom_range(0, 99) < 3), cur_ifr, cur_ia, cur_dr, cur_da,
                  ($urandom_range(0, 99) < 10));
        end

        cycle(0, 0, 0, 0, 0, 0);
        cycle(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        #3;
        chk("if_q_drained", 64'(if_exp_q.size()), 64'd0);
        chk("dbg_q_drained", 64'(dbg_exp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
